// File: rtl/sram_pkg.sv
// Shared constants for the two-port SRAM arbiter: bus widths, timer sizing
// and the FSM state encodings.
package sram_pkg;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 32;
  localparam int TIMER_W     = 8;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection. 'last' is 1 when port 1 was the
// most recent grantee, so on a tie the other port goes next.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  // Pick a single winner: a lone request always wins, a tie goes to the port not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && (!req1 || last)) begin
      gnt0 = 1'b1;
    end else if (req1) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-command SRAM controller. One access
// is in flight at a time; it completes on ram_done or on a timeout, and the
// arbiter then waits for ram_done to fall before accepting the next request.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_done,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [TIMER_W-1:0] TMO_LAST_C = TIMER_W'(TIMEOUT - 1);

  logic [1:0]         state_r;
  logic [TIMER_W-1:0] timer_r;
  logic               owner_r;
  logic               last_r;
  logic               gnt0_s;
  logic               gnt1_s;
  logic               sel_we_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_wdata_s;

  rr_arb2 u_rr (
    .req0 (req0),
    .req1 (req1),
    .last (last_r),
    .gnt0 (gnt0_s),
    .gnt1 (gnt1_s)
  );

  // Route the winning port's command fields toward the command registers.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    if (gnt1_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Arbitration FSM with all port-side and controller-side outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      timer_r   <= {TIMER_W{1'b0}};
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= {DATA_W{1'b0}};
      rdata1    <= {DATA_W{1'b0}};
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= {ADDR_W{1'b0}};
      ram_wdata <= {DATA_W{1'b0}};
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A still-high ram_done belongs to an older access (e.g. one cut
          // short by reset), so no new command goes out until it drops.
          if ((gnt0_s || gnt1_s) && !ram_done) begin
            owner_r   <= gnt1_s;
            last_r    <= gnt1_s;
            ram_write <= sel_we_s;
            ram_read  <= !sel_we_s;
            ram_addr  <= sel_addr_s;
            ram_wdata <= sel_wdata_s;
            timer_r   <= {TIMER_W{1'b0}};
            state_r   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (ram_done) begin
            if (ram_read) begin
              if (owner_r) begin
                rdata1 <= ram_rdata;
              end else begin
                rdata0 <= ram_rdata;
              end
            end
            ack0      <= !owner_r;
            ack1      <= owner_r;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            state_r   <= ST_RELEASE;
          end else if (timer_r == TMO_LAST_C) begin
            ack0      <= !owner_r;
            ack1      <= owner_r;
            err0      <= !owner_r;
            err1      <= owner_r;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            state_r   <= ST_RELEASE;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        ST_RELEASE: begin
          if (!ram_done) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max cycles waited for ram_done per access (range 2..255).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1  input  1  access request, held by requester until its ack.
REQ-005 SHALL have ports we0/we1  input  1  1=write, 0=read, valid while reqN=1.
REQ-006 SHALL have ports addr0/addr1  input  20  word address; wdata0/wdata1  input  32  write data.
REQ-007 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse; err0/err1  output  1  one-cycle timeout pulse, coincident with ack.
REQ-008 SHALL have ports rdata0/rdata1  output  32  read result, valid from ack onward, held until that port's next read completes.
REQ-009 SHALL have ports ram_read/ram_write  output  1, ram_addr  output  20, ram_wdata  output  32  command to SRAM controller.
REQ-010 SHALL have ports ram_done  input  1, ram_rdata  input  32  controller completion flag and read data.

Function
REQ-011 SHALL implement FSM IDLE, BUSY, RELEASE; all outputs registered.
REQ-012 IDLE: SHALL sample req0/req1; if any set, latch winner's we/addr/wdata into ram_write/ram_read/ram_addr/ram_wdata, record owner, clear timer, go BUSY next edge.
REQ-013 Arbitration SHALL be round-robin: single request wins; on simultaneous requests the port not granted last wins; after reset port 0 wins the first tie.
REQ-014 Exactly one of ram_read/ram_write SHALL be 1 in BUSY; command and address SHALL stay stable throughout BUSY.
REQ-015 BUSY: on ram_done=1, SHALL capture ram_rdata into owner's rdata (reads only), pulse owner's ack for one cycle, deassert ram_read/ram_write, go RELEASE.
REQ-016 BUSY: timer SHALL increment each cycle; if timer reaches TIMEOUT-1 without ram_done, SHALL pulse owner's ack and err, leave rdata unchanged, deassert command, go RELEASE.
REQ-017 RELEASE: SHALL stay until ram_done=0, then go IDLE; RELEASE lasts at least one cycle.
REQ-018 Latency: req rising in IDLE -> command on next edge; ack on edge after ram_done seen; minimum request-to-request turnaround 4 cycles.
REQ-019 Requests SHALL be sampled only in IDLE; req changes in BUSY/RELEASE have no effect.
REQ-020 Non-owner ack/err SHALL remain 0; at most one ack asserted per cycle.
REQ-021 Request dropped before grant SHALL NOT be serviced; request dropped during BUSY SHALL still complete and ack.

Reset
REQ-022 On rst=0, asynchronously: state=IDLE, ram_read=ram_write=0, ram_addr=0, ram_wdata=0, ack0/1=0, err0/1=0, rdata0/1=0, timer=0, last-grant pointer=port 1.
REQ-023 Reset mid-BUSY SHALL abort the access with no ack; first post-reset access SHALL wait for ram_done=0 (enter via IDLE only after ram_done low).

Structure
REQ-024 FSM state encodings, TIMEOUT default, address/data widths SHALL live in shared package sram_pkg.
REQ-025 Round-robin winner selection SHALL be a sub-module rr_arb2 (inputs req0, req1, last; outputs gnt0, gnt1).

Verification
REQ-026 Single read: req0=1, we0=0, addr0=0x00010; model returns 0xDEADBEEF after 5 cycles -> ram_read=1 with ram_addr=0x00010, ack0 one pulse, rdata0=0xDEADBEEF, err0=0.
REQ-027 Tie: req0=req1=1 after reset, write addr0=0x00001/wdata0=0x11111111, read addr1=0x00002 -> port 0 served first, port 1 second, ack0 precedes ack1.
REQ-028 Fairness: both held continuously for 6 accesses -> grants alternate 0,1,0,1,0,1.
REQ-029 Timeout: ram_done held 0, TIMEOUT=8 -> ack1 and err1 pulse 8 cycles after grant, rdata1 unchanged, command deasserted.
REQ-030 Release: ram_done held 1 for 3 cycles after ack -> no new command until ram_done=0, pending req0 then granted.
REQ-031 Reset mid-BUSY: rst=0 during write -> all outputs 0 immediately, no ack; next read completes normally.
